multi_core_dm_responder: RTL and testbench



---
 rtl/dm_pkg.sv | 18 +
 rtl/rr_arbiter4.sv | 20 ++
 rtl/multi_core_dm_responder.sv | 215 +++++++++++++++++++++
 tb/tb_multi_core_dm_responder.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the four-core data-memory responder.
package dm_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int NCORES = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: the first request at or after i_ptr wins.
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_grant
);
    logic [1:0] w_idx;

    // Walk from the farthest offset down so the nearest request is assigned last.
    always_comb begin
        o_grant = 4'b0000;
        w_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_grant = 4'b0001 << w_idx;
            end
        end
    end
endmodule

// File: rtl/multi_core_dm_responder.sv
// Data-memory responder for four cores: write slots, round-robin commit, run sequencing.
// Optional macro WR_FORWARD_EN: core reads are forwarded from that core's pending slot.
module multi_core_dm_responder
    import dm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_data_0,
    input  logic [ADDR_W-1:0] addr_data_1,
    input  logic [ADDR_W-1:0] addr_data_2,
    input  logic [ADDR_W-1:0] addr_data_3,
    input  logic [DATA_W-1:0] datain0,
    input  logic [DATA_W-1:0] datain1,
    input  logic [DATA_W-1:0] datain2,
    input  logic [DATA_W-1:0] datain3,
    input  logic              write_en0,
    input  logic              write_en1,
    input  logic              write_en2,
    input  logic              write_en3,
    output logic [DATA_W-1:0] dataout0,
    output logic [DATA_W-1:0] dataout1,
    output logic [DATA_W-1:0] dataout2,
    output logic [DATA_W-1:0] dataout3,
    output logic [1:0]        status0,
    output logic [1:0]        status1,
    output logic [1:0]        status2,
    output logic [1:0]        status3,
    input  logic [3:0]        end_process,
    input  logic              host_start,
    input  logic [3:0]        host_en,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              run_done,
    output logic [3:0]        wr_overflow
);
    state_t              r_state;
    state_t              w_next;
    logic [NCORES-1:0]   r_en_q;
    logic [NCORES-1:0]   r_done_mask;
    slot_t               r_slot [NCORES];
    logic [1:0]          r_ptr;
    logic [NCORES-1:0]   r_ovf;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_dout [NCORES];
    logic [DATA_W-1:0]   r_host_rdata;

    logic [ADDR_W-1:0]   w_addr [NCORES];
    logic [DATA_W-1:0]   w_din [NCORES];
    logic [DATA_W-1:0]   w_rd [NCORES];
    logic [1:0]          w_status [NCORES];
    logic [NCORES-1:0]   w_we;
    logic [NCORES-1:0]   w_ep;
    logic [NCORES-1:0]   w_req;
    logic [NCORES-1:0]   w_grant;
    logic [1:0]          w_win;
    logic                w_all_done;
    logic                w_run_done;

    assign w_addr[0] = addr_data_0;
    assign w_addr[1] = addr_data_1;
    assign w_addr[2] = addr_data_2;
    assign w_addr[3] = addr_data_3;
    assign w_din[0]  = datain0;
    assign w_din[1]  = datain1;
    assign w_din[2]  = datain2;
    assign w_din[3]  = datain3;
    assign w_we      = {write_en3, write_en2, write_en1, write_en0};
    // end_process is MSB-first by core; reorder so bit i is core i.
    assign w_ep      = {end_process[0], end_process[1], end_process[2], end_process[3]};

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            w_req[i] = r_slot[i].valid;
        end
    end

    rr_arbiter4 u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_win = 2'd0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_grant[i]) begin
                w_win = 2'(i);
            end
        end
    end

    assign w_all_done = (((r_done_mask | w_ep) & r_en_q) == r_en_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (host_start) w_next = (host_en == 4'b0000) ? DONE : RUN;
            RUN:     if (w_all_done) w_next = DRAIN;
            DRAIN:   if (w_req == '0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_run_done = (r_state == DONE);
        for (int i = 0; i < NCORES; i++) begin
            w_status[i] = (r_state == RUN && r_en_q[i]) ? ST_RUN : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_q      <= '0;
            r_done_mask <= '0;
        end else begin
            case (r_state)
                IDLE:    if (host_start) begin
                             r_en_q      <= host_en;
                             r_done_mask <= '0;
                         end
                RUN:     r_done_mask <= r_done_mask | (w_ep & r_en_q);
                DONE:    r_done_mask <= '0;
                default: ;
            endcase
        end
    end

    // A slot that commits this cycle is free to take a new write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
            r_ovf <= '0;
            for (int i = 0; i < NCORES; i++) begin
                r_slot[i].valid <= 1'b0;
            end
        end else begin
            if (w_grant != '0) begin
                r_ptr <= w_win + 2'd1;
            end
            for (int i = 0; i < NCORES; i++) begin
                if (w_grant[i]) begin
                    r_slot[i].valid <= 1'b0;
                end
                if (r_state == RUN && w_we[i]) begin
                    if (!r_slot[i].valid || w_grant[i]) begin
                        r_slot[i] <= '{valid: 1'b1, addr: w_addr[i], data: w_din[i]};
                    end else begin
                        r_ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Reset discards pending slots, so a commit on the reset edge is suppressed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_grant != '0) begin
                r_mem[r_slot[w_win].addr] <= r_slot[w_win].data;
            end else if (r_state == IDLE && host_we) begin
                r_mem[host_addr] <= host_wdata;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            w_rd[i] = r_mem[w_addr[i]];
`ifdef WR_FORWARD_EN
            if (r_slot[i].valid && r_slot[i].addr == w_addr[i]) begin
                w_rd[i] = r_slot[i].data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_host_rdata <= '0;
            for (int i = 0; i < NCORES; i++) begin
                r_dout[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                r_dout[i] <= w_rd[i];
            end
            if (r_state == IDLE) begin
                r_host_rdata <= r_mem[host_addr];
            end
        end
    end

    assign dataout0    = r_dout[0];
    assign dataout1    = r_dout[1];
    assign dataout2    = r_dout[2];
    assign dataout3    = r_dout[3];
    assign status0     = w_status[0];
    assign status1     = w_status[1];
    assign status2     = w_status[2];
    assign status3     = w_status[3];
    assign host_rdata  = r_host_rdata;
    assign run_done    = w_run_done;
    assign wr_overflow = r_ovf;
endmodule

// File: tb/tb_multi_core_dm_responder.sv
// Directed bench for multi_core_dm_responder; honours WR_FORWARD_EN when defined.
module tb_multi_core_dm_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr_a [4];
    logic [15:0] din [4];
    logic [3:0]  wen;
    logic [15:0] dout [4];
    logic [1:0]  st [4];
    logic [3:0]  end_process;
    logic        host_start;
    logic [3:0]  host_en;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        run_done;
    logic [3:0]  wr_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_core_dm_responder dut (
        .clk         (clk),
        .rst         (rst),
        .addr_data_0 (addr_a[0]),
        .addr_data_1 (addr_a[1]),
        .addr_data_2 (addr_a[2]),
        .addr_data_3 (addr_a[3]),
        .datain0     (din[0]),
        .datain1     (din[1]),
        .datain2     (din[2]),
        .datain3     (din[3]),
        .write_en0   (wen[0]),
        .write_en1   (wen[1]),
        .write_en2   (wen[2]),
        .write_en3   (wen[3]),
        .dataout0    (dout[0]),
        .dataout1    (dout[1]),
        .dataout2    (dout[2]),
        .dataout3    (dout[3]),
        .status0     (st[0]),
        .status1     (st[1]),
        .status2     (st[2]),
        .status3     (st[3]),
        .end_process (end_process),
        .host_start  (host_start),
        .host_en     (host_en),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .run_done    (run_done),
        .wr_overflow (wr_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [15:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        tick();
        host_we    = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [15:0] d);
        host_addr = a;
        tick();
        d = host_rdata;
    endtask

    task automatic start_run(input logic [3:0] en);
        host_en    = en;
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    // Raise every done flag and count run_done pulses over a bounded window.
    task automatic finish_run(output int pulses);
        pulses      = 0;
        end_process = 4'hF;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (run_done === 1'b1) pulses++;
        end
        end_process = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st[i] !== 2'b00) begin
                errors++;
                $display("FAIL reset_status%0d got %b want 00", i, st[i]);
            end
            checks++;
            if (dout[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_dataout%0d got %h want 0000", i, dout[i]);
            end
        end
        checks++;
        if (host_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_host_rdata got %h want 0000", host_rdata);
        end
        checks++;
        if (run_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_run_done got %b want 0", run_done);
        end
        checks++;
        if (wr_overflow !== 4'b0000) begin
            errors++;
            $display("FAIL reset_overflow got %b want 0000", wr_overflow);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_host_preload();
        logic [15:0] v;
        host_write(8'h10, 16'h1234);
        host_write(8'h11, 16'h0011);
        host_write(8'h30, 16'h5555);
        for (int a = 8'h20; a <= 8'h23; a++) host_write(8'(a), 16'h0000);
        for (int a = 8'h40; a <= 8'h5F; a++) host_write(8'(a), 16'h0000);
        for (int a = 8'h60; a <= 8'h63; a++) host_write(8'(a), 16'h0000);
        host_read(8'h10, v);
        checks++;
        if (v !== 16'h1234) begin
            errors++;
            $display("FAIL preload_0x10 got %h want 1234", v);
        end
        // Core writes outside a run must not reach memory.
        addr_a[0] = 8'h10;
        din[0]    = 16'hFFFF;
        wen       = 4'b0001;
        tick();
        wen = 4'b0000;
        repeat (5) tick();
        host_read(8'h10, v);
        checks++;
        if (v !== 16'h1234) begin
            errors++;
            $display("FAIL idle_core_write_ignored got %h want 1234", v);
        end
    endtask

    task automatic test_single_run();
        int          pulses;
        logic [15:0] v;
        start_run(4'hF);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st[i] !== 2'b01) begin
                errors++;
                $display("FAIL run_status%0d got %b want 01", i, st[i]);
            end
        end
        host_write(8'h11, 16'hFFFF);
        end_process = 4'b1000;
        tick();
        end_process = 4'b0000;
        repeat (3) tick();
        checks++;
        if (st[0] !== 2'b01) begin
            errors++;
            $display("FAIL partial_done_still_run got %b want 01", st[0]);
        end
        // Core0's earlier flag must still count once the rest arrive.
        end_process = 4'b0111;
        tick();
        end_process = 4'b0000;
        checks++;
        if (st[0] !== 2'b00) begin
            errors++;
            $display("FAIL done_mask_sticky_drain got %b want 00", st[0]);
        end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (run_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL single_run_done_pulses got %0d want 1", pulses);
        end
        host_read(8'h11, v);
        checks++;
        if (v !== 16'h0011) begin
            errors++;
            $display("FAIL host_write_ignored_in_run got %h want 0011", v);
        end
    endtask

    task automatic test_zero_enable();
        start_run(4'h0);
        checks++;
        if (run_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_en_run_done got %b want 1", run_done);
        end
        tick();
        checks++;
        if (run_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_en_run_done_end got %b want 0", run_done);
        end
    endtask

    task automatic test_simultaneous();
        int          pulses;
        logic [15:0] v;
        logic [15:0] exp;
        start_run(4'hF);
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = 8'h20 + 8'(i);
            din[i]    = 16'h00A0 + 16'(i);
        end
        wen = 4'hF;
        tick();
        wen = 4'h0;
        // Pointer starts at 0: core i commits on the (i+1)th edge, visible one read later.
        for (int k = 1; k <= 5; k++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
`ifdef WR_FORWARD_EN
                exp = 16'h00A0 + 16'(i);
`else
                exp = (k >= i + 2) ? 16'h00A0 + 16'(i) : 16'h0000;
`endif
                checks++;
                if (dout[i] !== exp) begin
                    errors++;
                    $display("FAIL rr_order core%0d cycle%0d got %h want %h", i, k, dout[i], exp);
                end
            end
        end
        finish_run(pulses);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL simul_run_done_pulses got %0d want 1", pulses);
        end
        for (int i = 0; i < 4; i++) begin
            host_read(8'h20 + 8'(i), v);
            checks++;
            if (v !== 16'h00A0 + 16'(i)) begin
                errors++;
                $display("FAIL simul_mem core%0d got %h want %h", i, v, 16'h00A0 + 16'(i));
            end
        end
        checks++;
        if (wr_overflow !== 4'b0000) begin
            errors++;
            $display("FAIL simul_no_overflow got %b want 0000", wr_overflow);
        end
    endtask

    task automatic test_overflow();
        int          pulses;
        logic [15:0] v;
        logic [15:0] exp;
        start_run(4'hF);
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 4; i++) begin
                addr_a[i] = 8'h40 + 8'(i * 8 + c);
                din[i]    = 16'hC000 | 16'(i << 4) | 16'(c);
            end
            wen = 4'hF;
            tick();
        end
        wen = 4'h0;
        finish_run(pulses);
        // One commit per cycle against four writers: every slot drops words, not just core2.
        checks++;
        if (wr_overflow !== 4'b1111) begin
            errors++;
            $display("FAIL overflow_flags got %b want 1111", wr_overflow);
        end
        // Each core keeps its first word plus the one taken on the edge its slot drained (cycle i+1).
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 5; c++) begin
                exp = (c == 0 || c == i + 1) ? (16'hC000 | 16'(i << 4) | 16'(c)) : 16'h0000;
                host_read(8'h40 + 8'(i * 8 + c), v);
                checks++;
                if (v !== exp) begin
                    errors++;
                    $display("FAIL overflow_mem core%0d word%0d got %h want %h", i, c, v, exp);
                end
            end
        end
    endtask

    task automatic test_forwarding();
        int          pulses;
        logic [15:0] exp;
        start_run(4'hF);
        addr_a[0] = 8'h30;
        din[0]    = 16'hBEEF;
        wen       = 4'b0001;
        tick();
        wen = 4'b0000;
        tick();
`ifdef WR_FORWARD_EN
        exp = 16'hBEEF;
`else
        exp = 16'h5555;
`endif
        checks++;
        if (dout[0] !== exp) begin
            errors++;
            $display("FAIL forward_read_during_commit got %h want %h", dout[0], exp);
        end
        tick();
        checks++;
        if (dout[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_after_commit got %h want beef", dout[0]);
        end
        finish_run(pulses);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL forward_run_done_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        int          pulses;
        logic [15:0] v;
        start_run(4'hF);
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = 8'h60 + 8'(i);
            din[i]    = 16'h00D0 + 16'(i);
        end
        wen = 4'hF;
        tick();
        wen = 4'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st[i] !== 2'b00) begin
                errors++;
                $display("FAIL midrst_status%0d got %b want 00", i, st[i]);
            end
        end
        checks++;
        if (wr_overflow !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_overflow_cleared got %b want 0000", wr_overflow);
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (run_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midrst_run_done got %0d pulses want 0", pulses);
        end
        for (int i = 0; i < 4; i++) begin
            host_read(8'h60 + 8'(i), v);
            checks++;
            if (v !== 16'h0000) begin
                errors++;
                $display("FAIL midrst_slot%0d_committed got %h want 0000", i, v);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        wen         = 4'h0;
        end_process = 4'h0;
        host_start  = 1'b0;
        host_en     = 4'h0;
        host_we     = 1'b0;
        host_addr   = 8'h00;
        host_wdata  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = 8'h00;
            din[i]    = 16'h0000;
        end
        test_reset();
        test_host_preload();
        test_single_run();
        test_zero_enable();
        test_simultaneous();
        test_overflow();
        test_forwarding();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
